// File: rtl/mac_acc_pkg.sv
// Shared types and default widths for the block result accumulator.
// The ACC_SATURATE_EN build option is handled in acc_sat_add.
package mac_acc_pkg;

   typedef enum logic {ACCUM, HOLD} state_t;

   localparam int unsigned DATA_W_DEF    = 32;
   localparam int unsigned ACC_W_DEF     = 40;
   localparam int unsigned BLOCK_LEN_DEF = 4;

   // Width of a count that must hold 0..block_len inclusive.
   function automatic int unsigned cnt_w(input int unsigned block_len);
      return $clog2(block_len + 1);
   endfunction

endpackage

// File: rtl/mac_result_accum_if.sv
// Input sample stream plus block result stream of mac_result_accum.
// The slave modport is the accumulator side; the master modport is the producer/consumer side.
interface mac_result_accum_if
   import mac_acc_pkg::*;
#(
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter int unsigned ACC_W     = ACC_W_DEF,
   parameter int unsigned BLOCK_LEN = BLOCK_LEN_DEF
);
   localparam int unsigned CNT_W = cnt_w(BLOCK_LEN);

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_sum;
   logic [CNT_W-1:0]  out_count;
   logic              out_ovf;

   modport master (
      output in_valid, in_data, flush, out_ready,
      input  in_ready, out_valid, out_sum, out_count, out_ovf
   );

   modport slave (
      input  in_valid, in_data, flush, out_ready,
      output in_ready, out_valid, out_sum, out_count, out_ovf
   );

endinterface

// File: rtl/acc_sat_add.sv
// Combinational accumulator adder with carry-out overflow flag.
// Build option ACC_SATURATE_EN clamps the sum to all-ones on overflow; otherwise it wraps.
module acc_sat_add #(
   parameter int unsigned ACC_W = 40
) (
   input  logic [ACC_W-1:0] acc,
   input  logic [ACC_W-1:0] data,
   output logic [ACC_W-1:0] sum,
   output logic             ovf
);

   logic [ACC_W:0] wide;

   assign wide = {1'b0, acc} + {1'b0, data};
   assign ovf  = wide[ACC_W];

`ifdef ACC_SATURATE_EN
   assign sum = ovf ? '1 : wide[ACC_W-1:0];
`else
   assign sum = wide[ACC_W-1:0];
`endif

endmodule

// File: rtl/mac_result_accum.sv
// Sums BLOCK_LEN consecutive results (or a flushed partial block) into one block total.
// Overflow handling (wrap vs. clamp) is selected by ACC_SATURATE_EN inside acc_sat_add.
module mac_result_accum
   import mac_acc_pkg::*;
#(
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter int unsigned ACC_W     = ACC_W_DEF,
   parameter int unsigned BLOCK_LEN = BLOCK_LEN_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   mac_result_accum_if.slave bus
);

   localparam int unsigned CNT_W = cnt_w(BLOCK_LEN);

   state_t           state;
   state_t           state_nxt;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_upd;
   logic [ACC_W-1:0] add_sum;
   logic [ACC_W-1:0] data_ext;
   logic             add_ovf;
   logic             ovf;
   logic             ovf_upd;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_upd;
   logic             accept;
   logic             close;
   logic [ACC_W-1:0] sum_q;
   logic [CNT_W-1:0] count_q;
   logic             ovf_q;

   assign data_ext = ACC_W'(bus.in_data);

   acc_sat_add #(.ACC_W(ACC_W)) u_add (
      .acc  (acc),
      .data (data_ext),
      .sum  (add_sum),
      .ovf  (add_ovf)
   );

   // Running values including this cycle's sample; used both to continue and to close a block.
   assign accept  = bus.in_valid && (state == ACCUM);
   assign cnt_upd = cnt + CNT_W'(accept);
   assign acc_upd = accept ? add_sum : acc;
   assign ovf_upd = ovf | (accept & add_ovf);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ACCUM;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      close         = 1'b0;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      unique case (state)
         ACCUM: begin
            bus.in_ready = 1'b1;
            close = (accept && cnt_upd == CNT_W'(BLOCK_LEN)) ||
                    (bus.flush && cnt_upd != '0);
            if (close) state_nxt = HOLD;
         end
         HOLD: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_nxt = ACCUM;
         end
         default: state_nxt = ACCUM;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc     <= '0;
         cnt     <= '0;
         ovf     <= 1'b0;
         sum_q   <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else if (state == ACCUM) begin
         acc <= acc_upd;
         cnt <= cnt_upd;
         ovf <= ovf_upd;
         if (close) begin
            sum_q   <= acc_upd;
            count_q <= cnt_upd;
            ovf_q   <= ovf_upd;
         end
      end else if (bus.out_ready) begin
         acc <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end
   end

   assign bus.out_sum   = sum_q;
   assign bus.out_count = count_q;
   assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_mac_result_accum.sv
// Randomised bench for mac_result_accum (ACC_W=32 build) against an exact-arithmetic block model.
// Honours ACC_SATURATE_EN when computing expected overflow results.
module tb_mac_result_accum;

   localparam int unsigned DATA_W    = 32;
   localparam int unsigned ACC_W     = 32;
   localparam int unsigned BLOCK_LEN = 4;

   logic clk;
   logic rst_n;

   int unsigned vectors;
   int unsigned miscompares;

   mac_result_accum_if #(.DATA_W(DATA_W), .ACC_W(ACC_W), .BLOCK_LEN(BLOCK_LEN)) bus ();

   mac_result_accum #(.DATA_W(DATA_W), .ACC_W(ACC_W), .BLOCK_LEN(BLOCK_LEN)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: exact block sum in 64 bits; wrap/clamp applied only when the block closes.
   bit               pending;
   longint unsigned  blk;
   int unsigned      mcnt;
   logic [ACC_W-1:0] m_sum;
   logic [2:0]       m_cnt;
   logic             m_ovf;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending = 1'b0;
         blk     = 0;
         mcnt    = 0;
      end else if (pending) begin
         if (bus.out_ready) pending = 1'b0;
      end else begin
         if (bus.in_valid) begin
            blk  = blk + longint'(bus.in_data);
            mcnt = mcnt + 1;
         end
         if ((bus.in_valid && mcnt == BLOCK_LEN) || (bus.flush && mcnt > 0)) begin
            m_ovf = (blk >> ACC_W) != 0;
`ifdef ACC_SATURATE_EN
            m_sum = m_ovf ? '1 : blk[ACC_W-1:0];
`else
            m_sum = blk[ACC_W-1:0];
`endif
            m_cnt   = 3'(mcnt);
            pending = 1'b1;
            blk     = 0;
            mcnt    = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("in_ready", bus.in_ready, !pending);
         chk("out_valid", bus.out_valid, pending);
         if (pending) begin
            chk("out_sum", bus.out_sum, m_sum);
            chk("out_count", bus.out_count, m_cnt);
            chk("out_ovf", bus.out_ovf, m_ovf);
         end
      end
   end

   task automatic cyc(input logic v, input logic [31:0] d, input logic f, input logic r);
      @(posedge clk);
      #1;
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.flush     = f;
      bus.out_ready = r;
   endtask

   task automatic expect_blk(input string nm, input logic [63:0] s, input logic [63:0] c,
                             input logic o);
      int unsigned n;
      n = 0;
      @(negedge clk);
      while (!bus.out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!bus.out_valid) begin
         chk({nm, "_timeout"}, bus.out_valid, 1);
      end else begin
         chk({nm, "_sum"}, bus.out_sum, s);
         chk({nm, "_count"}, bus.out_count, c);
         chk({nm, "_ovf"}, bus.out_ovf, o);
      end
   endtask

   task automatic ones_block(input string nm);
      for (int i = 0; i < 4; i++) cyc(1'b1, 32'd1, 1'b0, 1'b1);
      cyc(1'b0, '0, 1'b0, 1'b1);
      expect_blk(nm, 4, 4, 1'b0);
   endtask

   initial begin
      vectors       = 0;
      miscompares   = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;

      // Reset
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_sum", bus.out_sum, 0);
      chk("rst_out_count", bus.out_count, 0);
      chk("rst_out_ovf", bus.out_ovf, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Full block, consumer ready
      cyc(1'b1, 32'd90, 1'b0, 1'b1);
      cyc(1'b1, 32'd300, 1'b0, 1'b1);
      cyc(1'b1, 32'd2, 1'b0, 1'b1);
      cyc(1'b1, 32'd8, 1'b0, 1'b1);
      cyc(1'b0, '0, 1'b0, 1'b1);
      expect_blk("full", 400, 4, 1'b0);
      chk("full_in_ready_hold", bus.in_ready, 0);
      @(negedge clk);
      chk("full_one_cycle", bus.out_valid, 0);

      // Backpressure with ignored input traffic
      cyc(1'b1, 32'd90, 1'b0, 1'b0);
      cyc(1'b1, 32'd300, 1'b0, 1'b0);
      cyc(1'b1, 32'd2, 1'b0, 1'b0);
      cyc(1'b1, 32'd8, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) cyc(1'b1, $urandom, 1'b0, 1'b0);
      @(negedge clk);
      chk("bp_sum", bus.out_sum, 400);
      chk("bp_in_ready", bus.in_ready, 0);
      cyc(1'b0, '0, 1'b0, 1'b1);
      ones_block("bp_next");

      // Flush with a same-cycle sample, then flush of an empty block
      cyc(1'b1, 32'd10, 1'b0, 1'b1);
      cyc(1'b1, 32'd20, 1'b0, 1'b1);
      cyc(1'b1, 32'd30, 1'b1, 1'b1);
      cyc(1'b0, '0, 1'b0, 1'b1);
      expect_blk("flush", 60, 3, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b1);
      cyc(1'b0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("empty_flush", bus.out_valid, 0);
      end

      // Overflow
      cyc(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
      cyc(1'b1, 32'd5, 1'b1, 1'b1);
      cyc(1'b0, '0, 1'b0, 1'b1);
`ifdef ACC_SATURATE_EN
      expect_blk("ovf", 64'hFFFF_FFFF, 2, 1'b1);
`else
      expect_blk("ovf", 4, 2, 1'b1);
`endif
      ones_block("ovf_next");

      // Asynchronous reset mid-block
      cyc(1'b1, 32'd7, 1'b0, 1'b1);
      cyc(1'b1, 32'd9, 1'b0, 1'b1);
      cyc(1'b0, '0, 1'b0, 1'b1);
      #1 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      ones_block("midrst");

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         cyc($urandom_range(0, 3) != 0,
             ($urandom_range(0, 3) == 0) ? (32'hF000_0000 | $urandom) : 32'($urandom_range(0, 1000)),
             $urandom_range(0, 7) == 0,
             $urandom_range(0, 9) < 7);
      end
      cyc(1'b0, '0, 1'b0, 1'b1);
      repeat (4) @(posedge clk);
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
